// File: rtl/scs8hd_clkmon_pkg.sv
// Shared types and constants for the scs8hd_clkmon clock monitor.
// Optional duty-cycle check is enabled by defining SCS8HD_CLKMON_DUTY_EN.
package scs8hd_clkmon_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        MEASURE,
        LOCKED,
        FAULT
    } state_t;

    localparam int unsigned CW_DEF          = 12;
    localparam int unsigned SYNC_STAGES_DEF = 2;
    localparam int unsigned LOCK_CNT_DEF    = 4;
    localparam bit          INVERT_DEF      = 1'b0;

    // All-ones value of a width-bit counter: where the period counter stops.
    function automatic int unsigned sat_limit(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/scs8hd_clkmon_sync.sv
// Synchronizes the monitored clock into the reference domain and emits a
// one-cycle pulse on each synchronized rising edge (falling edge if INVERT).
module scs8hd_clkmon_sync
    import scs8hd_clkmon_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
    parameter bit          INVERT      = INVERT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic mon_clk,
    output logic level,
    output logic rise
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            chain <= '0;
            prev  <= 1'b0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], mon_clk ^ INVERT};
            prev  <= chain[SYNC_STAGES-1];
        end
    end

    assign level = chain[SYNC_STAGES-1];
    assign rise  = level & ~prev;

endmodule

// File: rtl/scs8hd_clkmon.sv
// Clock monitor: measures mon_clk period in clk cycles, locks after LOCK_CNT
// in-window periods, flags drift/stuck faults. Define SCS8HD_CLKMON_DUTY_EN for high_time/duty check.
module scs8hd_clkmon
    import scs8hd_clkmon_pkg::*;
#(
    parameter int unsigned CW          = CW_DEF,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int unsigned LOCK_CNT    = LOCK_CNT_DEF,
    parameter bit          INVERT      = INVERT_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          mon_clk,
    input  logic [CW-1:0] period_lo,
    input  logic [CW-1:0] period_hi,
    output logic [CW-1:0] period,
    output logic          period_vld,
    output logic          locked,
    output logic          fault,
    output logic          stuck
`ifdef SCS8HD_CLKMON_DUTY_EN
   ,output logic [CW-1:0] high_time
`endif
);

    localparam logic [CW-1:0] SAT       = CW'(sat_limit(CW));
    localparam logic [3:0]    GOOD_LAST = 4'(LOCK_CNT - 1);

    state_t        state, state_nx;
    logic [CW-1:0] cnt, meas;
    logic [3:0]    good;
    logic          level, rise, sat_hit, in_win, duty_ok;

    scs8hd_clkmon_sync #(
        .SYNC_STAGES(SYNC_STAGES),
        .INVERT     (INVERT)
    ) u_sync (
        .clk    (clk),
        .reset  (reset),
        .mon_clk(mon_clk),
        .level  (level),
        .rise   (rise)
    );

    // An edge arriving on the saturation cycle still reports a (clamped) period.
    assign meas    = (cnt == SAT) ? SAT : cnt + 1'b1;
    assign sat_hit = (cnt == SAT) && !rise;
    assign in_win  = (meas >= period_lo) && (meas <= period_hi) && duty_ok;

`ifdef SCS8HD_CLKMON_DUTY_EN
    logic [CW-1:0] hcnt, hmeas;
    logic [CW+1:0] h4, p1, p3;

    // The edge cycle itself is high, hence the +1.
    assign hmeas   = (hcnt == SAT) ? SAT : hcnt + 1'b1;
    assign h4      = {hmeas, 2'b00};
    assign p1      = {2'b00, meas};
    assign p3      = p1 + {1'b0, meas, 1'b0};
    assign duty_ok = (h4 >= p1) && (h4 <= p3);

    always_ff @(posedge clk) begin
        if (reset) begin
            hcnt      <= '0;
            high_time <= '0;
        end else begin
            if (en && rise && (state == MEASURE || state == LOCKED))
                high_time <= hmeas;
            if (!en || state == IDLE || rise)
                hcnt <= '0;
            else if (level && !sat_hit && state != FAULT)
                hcnt <= hcnt + 1'b1;
        end
    end
`else
    assign duty_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            good       <= '0;
            period     <= '0;
            period_vld <= 1'b0;
            stuck      <= 1'b0;
        end else begin
            period_vld <= 1'b0;
            if (!en || state == IDLE) begin
                cnt   <= '0;
                good  <= '0;
                stuck <= 1'b0;
            end else if (state != FAULT) begin
                if (rise) begin
                    cnt <= '0;
                    if (state != ARM) begin
                        period     <= meas;
                        period_vld <= 1'b1;
                        good       <= (in_win && good != GOOD_LAST) ? good + 1'b1 : '0;
                    end
                end else if (sat_hit) begin
                    stuck <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (!en) begin
            state_nx = IDLE;
        end else begin
            unique case (state)
                IDLE:    state_nx = ARM;
                ARM: begin
                    if (rise)         state_nx = MEASURE;
                    else if (sat_hit) state_nx = FAULT;
                end
                MEASURE: begin
                    if (rise) begin
                        if (in_win && good == GOOD_LAST) state_nx = LOCKED;
                    end else if (sat_hit) begin
                        state_nx = FAULT;
                    end
                end
                LOCKED: begin
                    if (rise) begin
                        if (!in_win) state_nx = FAULT;
                    end else if (sat_hit) begin
                        state_nx = FAULT;
                    end
                end
                FAULT:   state_nx = FAULT;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_comb begin
        locked = (state == LOCKED);
        fault  = (state == FAULT);
    end

endmodule

// File: tb/tb_scs8hd_clkmon.sv
// Self-checking bench for scs8hd_clkmon (CW=8, 2 sync stages, LOCK_CNT=4, window 9..11 for directed tests).
// Duty checks are active when SCS8HD_CLKMON_DUTY_EN is defined.
module tb_scs8hd_clkmon;

    localparam int unsigned CW   = 8;
    localparam int          SATV = 255;
    localparam int          NH   = 32768;

    logic          clk = 1'b0;
    logic          reset, en, mon_clk;
    logic [CW-1:0] period_lo, period_hi, period;
    logic          period_vld, locked, fault, stuck;
`ifdef SCS8HD_CLKMON_DUTY_EN
    logic [CW-1:0] high_time;
`endif

    scs8hd_clkmon #(
        .CW         (CW),
        .SYNC_STAGES(2),
        .LOCK_CNT   (4),
        .INVERT     (1'b0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .mon_clk   (mon_clk),
        .period_lo (period_lo),
        .period_hi (period_hi),
        .period    (period),
        .period_vld(period_vld),
        .locked    (locked),
        .fault     (fault),
        .stuck     (stuck)
`ifdef SCS8HD_CLKMON_DUTY_EN
       ,.high_time (high_time)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: timestamps of the last edge instead of counters.
    typedef enum {M_IDLE, M_ARM, M_MEAS, M_LOCK, M_FAULT} mmode_t;
    mmode_t mode = M_IDLE;
    int cyc = 0, t_ref = 0, good = 0, hacc = 0;
    int e_period = 0, e_high = 0;
    bit e_vld = 1'b0, e_stuck = 1'b0, m_rise = 1'b0;
    bit mon_h[NH], rst_h[NH], lvl_h[NH];

    int n_vec = 0, n_err = 0;
    int vld_seen = 0, lock_at = 0, fault_at = 0;
    int rises[$];
    bit last_mon = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic compare_all();
        check("period", int'(period), e_period);
        check("period_vld", int'(period_vld), int'(e_vld));
        check("locked", int'(locked), int'(mode == M_LOCK));
        check("fault", int'(fault), int'(mode == M_FAULT));
        check("stuck", int'(stuck), int'(e_stuck));
`ifdef SCS8HD_CLKMON_DUTY_EN
        check("high_time", int'(high_time), e_high);
`endif
    endtask

    task automatic model_tick(input bit r, input bit e, input bit m);
        int el, p;
        bit rs, inwin, lv, pv;
        rs = m_rise;
        hacc += int'(lvl_h[cyc]);
        cyc++;
        mon_h[cyc] = m;
        rst_h[cyc] = r;
        // synced level lags the driven value by two clocks
        lv = (r || rst_h[cyc-1]) ? 1'b0 : mon_h[cyc-1];
        pv = r ? 1'b0 : lvl_h[cyc-1];
        lvl_h[cyc] = lv;
        m_rise = lv & ~pv;
        el = cyc - t_ref;
        e_vld = 1'b0;
        if (r) begin
            mode = M_IDLE; good = 0; e_period = 0; e_stuck = 1'b0; e_high = 0;
        end else if (!e) begin
            mode = M_IDLE; good = 0; e_stuck = 1'b0;
        end else begin
            case (mode)
                M_IDLE: begin mode = M_ARM; t_ref = cyc; hacc = 0; end
                M_ARM: begin
                    if (rs) begin mode = M_MEAS; t_ref = cyc; hacc = 0; end
                    else if (el > SATV) begin mode = M_FAULT; e_stuck = 1'b1; end
                end
                M_MEAS, M_LOCK: begin
                    if (rs) begin
                        p = (el > SATV) ? SATV : el;
                        e_period = p;
                        e_vld = 1'b1;
                        e_high = (hacc > SATV) ? SATV : hacc;
                        inwin = (p >= int'(period_lo)) && (p <= int'(period_hi));
`ifdef SCS8HD_CLKMON_DUTY_EN
                        inwin = inwin && (4 * e_high >= p) && (4 * e_high <= 3 * p);
`endif
                        if (mode == M_MEAS) begin
                            good = inwin ? good + 1 : 0;
                            if (good == 4) begin mode = M_LOCK; good = 0; end
                        end else if (!inwin) begin
                            mode = M_FAULT;
                        end
                        t_ref = cyc;
                        hacc = 0;
                    end else if (el > SATV) begin
                        mode = M_FAULT; e_stuck = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic step(input bit r, input bit e, input bit m);
        @(negedge clk);
        compare_all();
        reset = r;
        en = e;
        mon_clk = m;
        if (m && !last_mon) rises.push_back(cyc + 1);
        last_mon = m;
        @(posedge clk);
        #1;
        model_tick(r, e, m);
        if (period_vld) vld_seen++;
        if (locked && lock_at == 0) lock_at = cyc;
        if (fault && fault_at == 0) fault_at = cyc;
    endtask

    task automatic wave(input int per, input int hi, input int n);
        for (int k = 0; k < n; k++)
            for (int i = 0; i < per; i++)
                step(1'b0, 1'b1, i < hi);
    endtask

    initial begin
        int per;
        reset = 1'b1; en = 1'b0; mon_clk = 1'b0;
        period_lo = 8'd9; period_hi = 8'd11;
        @(posedge clk);
        #1;
        model_tick(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        check("rst_period", int'(period), 0);
        check("rst_locked", int'(locked), 0);
        check("rst_fault", int'(fault), 0);
        check("rst_stuck", int'(stuck), 0);

        // lock on a steady period of 10
        step(1'b0, 1'b1, 1'b0);
        vld_seen = 0; lock_at = 0; rises.delete();
        wave(10, 5, 5);
        check("t1_vld_count", vld_seen, 4);
        check("t1_lock_time", lock_at, rises[4] + 2);
        check("t1_period", int'(period), 10);
        check("t1_fault", int'(fault), 0);

        // one long period while locked
        vld_seen = 0;
        wave(14, 7, 1);
        wave(10, 5, 1);
        check("t2_fault", int'(fault), 1);
        check("t2_locked", int'(locked), 0);
        check("t2_stuck", int'(stuck), 0);
        check("t2_period", int'(period), 14);
        check("t2_vld_count", vld_seen, 2);
        vld_seen = 0;
        wave(10, 5, 3);
        check("t2_no_vld", vld_seen, 0);

        // stuck clock after lock
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        wave(10, 5, 6);
        check("t3_locked", int'(locked), 1);
        fault_at = 0;
        for (int i = 0; i < 400 && fault_at == 0; i++) step(1'b0, 1'b1, 1'b0);
        check("t3_stuck_time", fault_at - rises[$], 258);
        check("t3_stuck", int'(stuck), 1);
        step(1'b0, 1'b0, 1'b0);
        check("t3_en_locked", int'(locked), 0);
        check("t3_en_fault", int'(fault), 0);
        check("t3_en_stuck", int'(stuck), 0);

        // an out-of-window period restarts the lock count
        step(1'b0, 1'b1, 1'b0);
        lock_at = 0; rises.delete();
        wave(10, 5, 2);
        wave(13, 6, 1);
        wave(10, 5, 5);
        check("t4_lock_time", lock_at, rises[7] + 2);

        // reset while locked
        step(1'b1, 1'b1, 1'b0);
        check("t5_period", int'(period), 0);
        check("t5_vld", int'(period_vld), 0);
        check("t5_locked", int'(locked), 0);
        check("t5_fault", int'(fault), 0);
        check("t5_stuck", int'(stuck), 0);
        vld_seen = 0;
        wave(10, 5, 1);
        check("t5_first_edge", vld_seen, 0);
        wave(10, 5, 1);
        check("t5_second_edge", vld_seen, 1);

        // edge on the saturation cycle, then one cycle too late
        step(1'b0, 1'b0, 1'b0);
        period_lo = 8'd200; period_hi = 8'd255;
        step(1'b0, 1'b1, 1'b0);
        wave(256, 100, 3);
        check("sat_period", int'(period), 255);
        check("sat_fault", int'(fault), 0);
        wave(257, 100, 2);
        check("sat_late_stuck", int'(stuck), 1);

`ifdef SCS8HD_CLKMON_DUTY_EN
        step(1'b0, 1'b0, 1'b0);
        period_lo = 8'd9; period_hi = 8'd11;
        step(1'b0, 1'b1, 1'b0);
        wave(10, 2, 8);
        check("t6_high_time", int'(high_time), 2);
        check("t6_no_lock", int'(locked), 0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        wave(10, 5, 6);
        check("t6_lock", int'(locked), 1);
`endif

        for (int seg = 0; seg < 60; seg++) begin
            int sel;
            sel = int'($urandom_range(0, 29));
            if (sel == 0) step(1'b1, 1'b1, 1'b0);
            else if (sel < 3) step(1'b0, 1'b0, 1'b0);
            else if (sel == 3) repeat (262) step(1'b0, 1'b1, 1'b0);
            if ($urandom_range(0, 3) == 0) begin
                period_lo = 8'($urandom_range(6, 12));
                period_hi = 8'($urandom_range(5, 14));
            end
            per = int'($urandom_range(6, 14));
            wave(per, int'($urandom_range(1, per - 1)), int'($urandom_range(1, 6)));
        end
        step(1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
